axi_sram_slave: RTL and testbench
=================================

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 Parameter AXI_ADDR_WIDTH, default 32, is the AXI address width.
REQ-002 Parameter AXI_DATA_WIDTH, default 64, is the AXI data width; strobe width SHALL be AXI_DATA_WIDTH/8.
REQ-003 Parameter AXI_ID_WIDTH, default 4, is the AXI ID width.
REQ-004 Parameter MEM_DEPTH, default 1024, is the number of AXI_DATA_WIDTH words of storage and SHALL be a power of 2.
REQ-005 Parameter BASE_ADDR, default 32'h8000_0000, is the byte address of word 0.
REQ-006 i_clk  input  1  clock; reset i_rst_n, synchronous, active-low; clock i_clk.
REQ-007 i_rst_n  input  1  synchronous active-low reset.
REQ-008 AxiIf_S  axi4_if.Slave  n/a  AXI4 slave port: AW, W, B, AR and R channels.

Function
REQ-009 The write and read paths SHALL be independent FSMs, each with one outstanding burst.
REQ-010 Write FSM states SHALL be W_IDLE, W_DATA and W_RESP; reset state is W_IDLE.
REQ-011 aw_ready SHALL be 1 only in W_IDLE with i_rst_n high; on aw_hs the FSM latches aw_addr, aw_len, aw_size and aw_id, clears the beat counter and moves to W_DATA.
REQ-012 In W_DATA, w_ready SHALL be 1, and each w_hs SHALL write to word ((addr-BASE_ADDR)>>log2(STRB)) mod MEM_DEPTH only the bytes whose w_strb bit is 1.
REQ-013 After each w_hs, addr SHALL increase by (1<<size) and the beat counter by 1; aw_burst is ignored and every burst is treated as INCR.
REQ-014 On w_hs with w_last=1 the FSM SHALL enter W_RESP; a beat whose counter already exceeds the latched len SHALL NOT be written.
REQ-015 In W_RESP, b_valid SHALL be 1, b_id = latched ID, and b_resp = 2'b00 (OKAY) unless REQ-024 applies; on b_hs the FSM returns to W_IDLE.
REQ-016 b_valid SHALL first assert the cycle after the last w_hs.
REQ-017 Read FSM states SHALL be R_IDLE and R_READ; reset state is R_IDLE.
REQ-018 ar_ready SHALL be 1 only in R_IDLE with i_rst_n high; on ar_hs the FSM latches addr, len, size and id, clears the beat counter and moves to R_READ.
REQ-019 In R_READ, r_valid SHALL be 1 and r_data SHALL be the full word at the current index, read combinationally with no lane shifting.
REQ-020 In R_READ, r_id SHALL equal the latched ID, r_last SHALL be (counter == len), and r_resp SHALL be OKAY unless REQ-024 applies.
REQ-021 On r_hs, addr and the counter SHALL advance per REQ-013; r_hs with r_last SHALL return the FSM to R_IDLE.
REQ-022 The first r_valid SHALL assert the cycle after ar_hs; with r_ready held at 1, one beat transfers per cycle.
REQ-023 A read and a write to the same word in the same cycle SHALL return the pre-write data; the write takes effect at that clock edge.
REQ-030 Unused slave outputs (r_user, b_user) SHALL be driven to 0.

Reset
REQ-025 While i_rst_n is low, aw_ready, w_ready, b_valid, ar_ready, r_valid and r_last SHALL be 0, and b_resp, r_resp, b_id, r_id and r_data SHALL be 0.
REQ-026 Reset asserted mid-burst SHALL abandon the burst; both FSMs return to idle and the counters clear.
REQ-027 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-024 With AXI_SLV_RANGE_CHK_EN defined, a beat whose address lies outside [BASE_ADDR, BASE_ADDR+MEM_DEPTH*STRB) SHALL NOT write.
REQ-031 With AXI_SLV_RANGE_CHK_EN defined, an out-of-range read beat SHALL return r_data=0 and r_resp=2'b10 (SLVERR).
REQ-032 With AXI_SLV_RANGE_CHK_EN defined, b_resp SHALL be SLVERR if any beat of the burst was out of range.
REQ-028 Without AXI_SLV_RANGE_CHK_EN, the index SHALL wrap modulo MEM_DEPTH and every response SHALL be OKAY.

Verification
REQ-029 The bench SHALL cover the following scenarios:
- Write addr 0x8000_0010, len 1, size 3, full strobe, data 0x1111.../0x2222... -> one b_hs with OKAY; a read of len 1 then returns both words in order, with r_last on beat 2.
- Write addr 0x8000_0008, size 0, strb 8'h04, data 0x00AB0000 over a word of 0 -> a read returns 0x0000_0000_00AB_0000.
- Write then read with r_ready toggled 1,0,1,0 -> r_data is stable while r_valid=1 and r_ready=0, and all beats are correct.
- Assert reset during W_DATA after 1 of 4 beats -> aw_ready=1 one cycle after reset release; the word written before reset is retained.
- With AXI_SLV_RANGE_CHK_EN, read at 0x7FFF_FFF8 -> r_resp=2'b10 and r_data=0; without the macro, the same read returns word MEM_DEPTH-1 with OKAY.

Source files
------------

// File: rtl/axi_sram_slave_if.sv
// AXI4 channel bundle (AW, W, B, AR, R) shared by the SRAM slave and its bench.
interface axi4_if #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4
);
    logic                        aw_valid;
    logic                        aw_ready;
    logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]                  aw_len;
    logic [2:0]                  aw_size;
    logic [1:0]                  aw_burst;
    logic [AXI_ID_WIDTH-1:0]     aw_id;
    logic                        w_valid;
    logic                        w_ready;
    logic [AXI_DATA_WIDTH-1:0]   w_data;
    logic [AXI_DATA_WIDTH/8-1:0] w_strb;
    logic                        w_last;
    logic                        b_valid;
    logic                        b_ready;
    logic [1:0]                  b_resp;
    logic [AXI_ID_WIDTH-1:0]     b_id;
    logic                        b_user;
    logic                        ar_valid;
    logic                        ar_ready;
    logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]                  ar_len;
    logic [2:0]                  ar_size;
    logic [1:0]                  ar_burst;
    logic [AXI_ID_WIDTH-1:0]     ar_id;
    logic                        r_valid;
    logic                        r_ready;
    logic [AXI_DATA_WIDTH-1:0]   r_data;
    logic [1:0]                  r_resp;
    logic [AXI_ID_WIDTH-1:0]     r_id;
    logic                        r_last;
    logic                        r_user;

    modport Slave (
        input  aw_valid, aw_addr, aw_len, aw_size, aw_burst, aw_id,
        output aw_ready,
        input  w_valid, w_data, w_strb, w_last,
        output w_ready,
        output b_valid, b_resp, b_id, b_user,
        input  b_ready,
        input  ar_valid, ar_addr, ar_len, ar_size, ar_burst, ar_id,
        output ar_ready,
        output r_valid, r_data, r_resp, r_id, r_last, r_user,
        input  r_ready
    );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI4 slave over a byte-writable SRAM: independent write/read FSMs, one burst each, INCR only.
// Define AXI_SLV_RANGE_CHK_EN to block out-of-window writes and answer them with SLVERR.
module axi_sram_slave #(
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter int                        AXI_DATA_WIDTH = 64,
    parameter int                        AXI_ID_WIDTH   = 4,
    parameter int                        MEM_DEPTH      = 1024,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h8000_0000
) (
    input logic   i_clk,
    input logic   i_rst_n,
    axi4_if.Slave AxiIf_S
);
    localparam int         STRB_W      = AXI_DATA_WIDTH / 8;
    localparam int         BYTE_SH     = $clog2(STRB_W);
    localparam int         IDX_W       = $clog2(MEM_DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
    typedef enum logic {R_IDLE = 1'b0, R_READ = 1'b1} r_state_e;

    logic [AXI_DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    w_state_e                  w_state_q, w_state_d;
    logic [AXI_ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [7:0]                w_len_q, w_len_d;
    logic [2:0]                w_size_q, w_size_d;
    logic [AXI_ID_WIDTH-1:0]   w_id_q, w_id_d;
    logic [8:0]                w_cnt_q, w_cnt_d;
    logic                      w_err_q, w_err_d;
    logic                      w_en_s, w_in_range_s;
    logic [IDX_W-1:0]          w_idx_s;

    r_state_e                  r_state_q, r_state_d;
    logic [AXI_ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
    logic [7:0]                r_len_q, r_len_d;
    logic [2:0]                r_size_q, r_size_d;
    logic [AXI_ID_WIDTH-1:0]   r_id_q, r_id_d;
    logic [7:0]                r_cnt_q, r_cnt_d;
    logic                      r_in_range_s;
    logic [IDX_W-1:0]          r_idx_s;

    logic                      aw_ready_s, w_ready_s, b_valid_s, ar_ready_s, r_valid_s, r_last_s;
    logic [1:0]                b_resp_s, r_resp_s;
    logic [AXI_ID_WIDTH-1:0]   b_id_s, r_id_s;
    logic [AXI_DATA_WIDTH-1:0] r_data_s;
    logic                      unused_s;

    // Word index wraps modulo MEM_DEPTH because only the low index bits are kept.
    function automatic logic [IDX_W-1:0] word_idx(input logic [AXI_ADDR_WIDTH-1:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> BYTE_SH);
    endfunction

`ifdef AXI_SLV_RANGE_CHK_EN
    localparam logic [AXI_ADDR_WIDTH:0] MEM_BYTES = (AXI_ADDR_WIDTH+1)'(MEM_DEPTH * STRB_W);

    // Addresses below BASE_ADDR wrap to huge offsets, so one unsigned compare covers both ends.
    function automatic logic in_range(input logic [AXI_ADDR_WIDTH-1:0] addr);
        return ({1'b0, addr - BASE_ADDR} < MEM_BYTES);
    endfunction

    assign w_in_range_s = in_range(w_addr_q);
    assign r_in_range_s = in_range(r_addr_q);
`else
    assign w_in_range_s = 1'b1;
    assign r_in_range_s = 1'b1;
`endif

    assign w_idx_s  = word_idx(w_addr_q);
    assign r_idx_s  = word_idx(r_addr_q);
    assign unused_s = ^{AxiIf_S.aw_burst, AxiIf_S.ar_burst};

    // Write FSM next state and channel outputs; everything idles low while reset is held.
    always_comb begin
        w_state_d  = w_state_q;
        w_addr_d   = w_addr_q;
        w_len_d    = w_len_q;
        w_size_d   = w_size_q;
        w_id_d     = w_id_q;
        w_cnt_d    = w_cnt_q;
        w_err_d    = w_err_q;
        w_en_s     = 1'b0;
        aw_ready_s = 1'b0;
        w_ready_s  = 1'b0;
        b_valid_s  = 1'b0;
        b_resp_s   = RESP_OKAY;
        b_id_s     = {AXI_ID_WIDTH{1'b0}};
        if (i_rst_n) begin
            case (w_state_q)
                W_IDLE: begin
                    aw_ready_s = 1'b1;
                    if (AxiIf_S.aw_valid) begin
                        w_addr_d  = AxiIf_S.aw_addr;
                        w_len_d   = AxiIf_S.aw_len;
                        w_size_d  = AxiIf_S.aw_size;
                        w_id_d    = AxiIf_S.aw_id;
                        w_cnt_d   = 9'd0;
                        w_err_d   = 1'b0;
                        w_state_d = W_DATA;
                    end else begin
                        w_state_d = W_IDLE;
                    end
                end
                W_DATA: begin
                    w_ready_s = 1'b1;
                    if (AxiIf_S.w_valid) begin
                        // Beats past the announced length are absorbed but never stored.
                        if (w_cnt_q <= {1'b0, w_len_q}) begin
                            w_en_s  = w_in_range_s;
                            w_err_d = w_err_q | ~w_in_range_s;
                        end else begin
                            w_en_s  = 1'b0;
                        end
                        w_addr_d  = w_addr_q + (AXI_ADDR_WIDTH'(1'b1) << w_size_q);
                        w_cnt_d   = w_cnt_q[8] ? w_cnt_q : w_cnt_q + 9'd1;
                        w_state_d = AxiIf_S.w_last ? W_RESP : W_DATA;
                    end else begin
                        w_state_d = W_DATA;
                    end
                end
                W_RESP: begin
                    b_valid_s = 1'b1;
                    b_resp_s  = w_err_q ? RESP_SLVERR : RESP_OKAY;
                    b_id_s    = w_id_q;
                    w_state_d = AxiIf_S.b_ready ? W_IDLE : W_RESP;
                end
                default: begin
                    w_state_d = W_IDLE;
                end
            endcase
        end else begin
            w_state_d = W_IDLE;
        end
    end

    // Write FSM state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            w_state_q <= W_IDLE;
            w_addr_q  <= {AXI_ADDR_WIDTH{1'b0}};
            w_len_q   <= 8'd0;
            w_size_q  <= 3'd0;
            w_id_q    <= {AXI_ID_WIDTH{1'b0}};
            w_cnt_q   <= 9'd0;
            w_err_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_size_q  <= w_size_d;
            w_id_q    <= w_id_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
        end
    end

    // Byte-lane write port; storage is deliberately left untouched by reset.
    always_ff @(posedge i_clk) begin
        if (w_en_s) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (AxiIf_S.w_strb[b]) begin
                    mem_q[w_idx_s][b*8 +: 8] <= AxiIf_S.w_data[b*8 +: 8];
                end
            end
        end
    end

    // Read FSM next state and R channel; data is read combinationally so a same-cycle write is not seen.
    always_comb begin
        r_state_d  = r_state_q;
        r_addr_d   = r_addr_q;
        r_len_d    = r_len_q;
        r_size_d   = r_size_q;
        r_id_d     = r_id_q;
        r_cnt_d    = r_cnt_q;
        ar_ready_s = 1'b0;
        r_valid_s  = 1'b0;
        r_last_s   = 1'b0;
        r_resp_s   = RESP_OKAY;
        r_id_s     = {AXI_ID_WIDTH{1'b0}};
        r_data_s   = {AXI_DATA_WIDTH{1'b0}};
        if (i_rst_n) begin
            case (r_state_q)
                R_IDLE: begin
                    ar_ready_s = 1'b1;
                    if (AxiIf_S.ar_valid) begin
                        r_addr_d  = AxiIf_S.ar_addr;
                        r_len_d   = AxiIf_S.ar_len;
                        r_size_d  = AxiIf_S.ar_size;
                        r_id_d    = AxiIf_S.ar_id;
                        r_cnt_d   = 8'd0;
                        r_state_d = R_READ;
                    end else begin
                        r_state_d = R_IDLE;
                    end
                end
                R_READ: begin
                    r_valid_s = 1'b1;
                    r_id_s    = r_id_q;
                    r_last_s  = (r_cnt_q == r_len_q);
                    if (r_in_range_s) begin
                        r_data_s = mem_q[r_idx_s];
                        r_resp_s = RESP_OKAY;
                    end else begin
                        r_data_s = {AXI_DATA_WIDTH{1'b0}};
                        r_resp_s = RESP_SLVERR;
                    end
                    if (AxiIf_S.r_ready) begin
                        r_addr_d  = r_addr_q + (AXI_ADDR_WIDTH'(1'b1) << r_size_q);
                        r_cnt_d   = r_cnt_q + 8'd1;
                        r_state_d = r_last_s ? R_IDLE : R_READ;
                    end else begin
                        r_state_d = R_READ;
                    end
                end
                default: begin
                    r_state_d = R_IDLE;
                end
            endcase
        end else begin
            r_state_d = R_IDLE;
        end
    end

    // Read FSM state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state_q <= R_IDLE;
            r_addr_q  <= {AXI_ADDR_WIDTH{1'b0}};
            r_len_q   <= 8'd0;
            r_size_q  <= 3'd0;
            r_id_q    <= {AXI_ID_WIDTH{1'b0}};
            r_cnt_q   <= 8'd0;
        end else begin
            r_state_q <= r_state_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_size_q  <= r_size_d;
            r_id_q    <= r_id_d;
            r_cnt_q   <= r_cnt_d;
        end
    end

    assign AxiIf_S.aw_ready = aw_ready_s;
    assign AxiIf_S.w_ready  = w_ready_s;
    assign AxiIf_S.b_valid  = b_valid_s;
    assign AxiIf_S.b_resp   = b_resp_s;
    assign AxiIf_S.b_id     = b_id_s;
    assign AxiIf_S.b_user   = 1'b0;
    assign AxiIf_S.ar_ready = ar_ready_s;
    assign AxiIf_S.r_valid  = r_valid_s;
    assign AxiIf_S.r_data   = r_data_s;
    assign AxiIf_S.r_resp   = r_resp_s;
    assign AxiIf_S.r_id     = r_id_s;
    assign AxiIf_S.r_last   = r_last_s;
    assign AxiIf_S.r_user   = 1'b0;
endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: vector table of bursts, reference memory model and
// response scoreboards, plus hand-written reset, byte-strobe and back-pressure sequences.
module tb_axi_sram_slave;
    localparam int          AW    = 32;
    localparam int          DW    = 64;
    localparam int          IW    = 4;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h8000_0000;
`ifdef AXI_SLV_RANGE_CHK_EN
    localparam logic [1:0]  OOR_RESP = 2'b10;
`else
    localparam logic [1:0]  OOR_RESP = 2'b00;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    axi4_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW)) bus ();

    axi_sram_slave #(
        .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW),
        .MEM_DEPTH(DEPTH), .BASE_ADDR(BASE)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .AxiIf_S (bus)
    );

    typedef struct { logic [63:0] data; logic [1:0] resp; logic last; logic [3:0] id; } rexp_t;
    typedef struct { logic [1:0] resp; logic [3:0] id; } bexp_t;
    typedef struct {
        bit          do_wr;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [7:0]  strb;
        logic [63:0] seed;
        logic [1:0]  exp_resp;
    } vec_t;

    rexp_t       r_q[$];
    bexp_t       b_q[$];
    logic [63:0] model_mem [DEPTH];
    vec_t        vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int m_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'(off[12:3]);
    endfunction

    function automatic bit m_inr(input logic [31:0] a);
`ifdef AXI_SLV_RANGE_CHK_EN
        logic [31:0] off;
        off = a - BASE;
        return (off < 32'd8192);
`else
        return (a == a);
`endif
    endfunction

    function automatic void m_write(input int idx, input logic [63:0] d, input logic [7:0] s);
        for (int b = 0; b < 8; b++) begin
            if (s[b]) model_mem[idx][b*8 +: 8] = d[b*8 +: 8];
        end
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [7:0] strb, input logic [63:0] seed, input logic [3:0] id,
                            input logic [1:0] exp_resp);
        logic [31:0] a;
        logic [63:0] d;
        int          cyc;
        bexp_t       be;
        @(negedge clk);
        bus.aw_valid = 1'b1; bus.aw_addr = addr; bus.aw_len = len;
        bus.aw_size  = size; bus.aw_burst = 2'b01; bus.aw_id = id;
        cyc = 0;
        while (bus.aw_ready !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
        check("aw_ready", 64'(bus.aw_ready), 64'd1);
        @(negedge clk);
        bus.aw_valid = 1'b0;
        a = addr;
        for (int k = 0; k <= int'(len); k++) begin
            d = seed * 64'(k + 1);
            bus.w_valid = 1'b1; bus.w_data = d; bus.w_strb = strb; bus.w_last = (k == int'(len));
            cyc = 0;
            while (bus.w_ready !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
            check("w_ready", 64'(bus.w_ready), 64'd1);
            if (m_inr(a)) m_write(m_idx(a), d, strb);
            a = a + (32'd1 << size);
            @(negedge clk);
        end
        bus.w_valid = 1'b0; bus.w_last = 1'b0;
        check("b_valid_latency", 64'(bus.b_valid), 64'd1);
        b_q.push_back('{resp: exp_resp, id: id});
        bus.b_ready = 1'b1;
        cyc = 0;
        while (bus.b_valid !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
        be = b_q.pop_front();
        check("b_resp", 64'(bus.b_resp), 64'(be.resp));
        check("b_id", 64'(bus.b_id), 64'(be.id));
        @(negedge clk);
        bus.b_ready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [3:0] id, input logic [1:0] exp_resp, input bit toggle);
        logic [31:0] a;
        logic [63:0] held_data;
        bit          held;
        int          cyc;
        int          beats;
        rexp_t       re;
        @(negedge clk);
        bus.ar_valid = 1'b1; bus.ar_addr = addr; bus.ar_len = len;
        bus.ar_size  = size; bus.ar_burst = 2'b01; bus.ar_id = id;
        cyc = 0;
        while (bus.ar_ready !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
        check("ar_ready", 64'(bus.ar_ready), 64'd1);
        a = addr;
        for (int k = 0; k <= int'(len); k++) begin
            re.data = m_inr(a) ? model_mem[m_idx(a)] : 64'd0;
            re.resp = exp_resp;
            re.last = (k == int'(len));
            re.id   = id;
            r_q.push_back(re);
            a = a + (32'd1 << size);
        end
        @(negedge clk);
        bus.ar_valid = 1'b0;
        check("r_valid_latency", 64'(bus.r_valid), 64'd1);
        beats = 0; held = 1'b0; held_data = 64'd0; cyc = 0;
        while (beats <= int'(len) && cyc < 8 * (int'(len) + 1) + 8) begin
            bus.r_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            if (bus.r_valid === 1'b1) begin
                if (held) check("r_data_stable", bus.r_data, held_data);
                if (bus.r_ready) begin
                    re = r_q.pop_front();
                    check("r_data", bus.r_data, re.data);
                    check("r_resp", 64'(bus.r_resp), 64'(re.resp));
                    check("r_last", 64'(bus.r_last), 64'(re.last));
                    check("r_id", 64'(bus.r_id), 64'(re.id));
                    beats++;
                    held = 1'b0;
                end else begin
                    held      = 1'b1;
                    held_data = bus.r_data;
                end
            end
            @(negedge clk);
            cyc++;
        end
        bus.r_ready = 1'b0;
        check("r_beats", 64'(beats), 64'(int'(len) + 1));
        r_q.delete();
    endtask

    task automatic check_reset_outputs();
        check("rst_aw_ready", 64'(bus.aw_ready), 64'd0);
        check("rst_w_ready", 64'(bus.w_ready), 64'd0);
        check("rst_b_valid", 64'(bus.b_valid), 64'd0);
        check("rst_ar_ready", 64'(bus.ar_ready), 64'd0);
        check("rst_r_valid", 64'(bus.r_valid), 64'd0);
        check("rst_r_last", 64'(bus.r_last), 64'd0);
        check("rst_b_resp", 64'(bus.b_resp), 64'd0);
        check("rst_r_resp", 64'(bus.r_resp), 64'd0);
        check("rst_b_id", 64'(bus.b_id), 64'd0);
        check("rst_r_id", 64'(bus.r_id), 64'd0);
        check("rst_r_data", bus.r_data, 64'd0);
        check("rst_b_user", 64'(bus.b_user), 64'd0);
        check("rst_r_user", 64'(bus.r_user), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.aw_valid = 1'b0; bus.aw_addr = 32'd0; bus.aw_len = 8'd0; bus.aw_size = 3'd0;
        bus.aw_burst = 2'b00; bus.aw_id = 4'd0;
        bus.w_valid = 1'b0; bus.w_data = 64'd0; bus.w_strb = 8'd0; bus.w_last = 1'b0;
        bus.b_ready = 1'b0;
        bus.ar_valid = 1'b0; bus.ar_addr = 32'd0; bus.ar_len = 8'd0; bus.ar_size = 3'd0;
        bus.ar_burst = 2'b00; bus.ar_id = 4'd0;
        bus.r_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 64'd0;

        vecs[0] = '{1'b1, 32'h8000_0010, 8'd1, 3'd3, 8'hFF, 64'h1111_1111_1111_1111, 2'b00};
        vecs[1] = '{1'b1, 32'h8000_0100, 8'd3, 3'd3, 8'hFF, 64'h0102_0304_0506_0708, 2'b00};
        vecs[2] = '{1'b1, 32'h8000_0200, 8'd0, 3'd3, 8'hF0, 64'hA5A5_A5A5_5A5A_5A5A, 2'b00};
        vecs[3] = '{1'b1, 32'h8000_0300, 8'd7, 3'd2, 8'hFF, 64'h1357_9BDF_0246_8ACE, 2'b00};
        vecs[4] = '{1'b1, 32'h8000_0400, 8'd2, 3'd3, 8'h0F, 64'h0F0E_0D0C_0B0A_0908, 2'b00};
        vecs[5] = '{1'b1, 32'h8000_1FF8, 8'd0, 3'd3, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 2'b00};
        vecs[6] = '{1'b0, 32'h7FFF_FFF8, 8'd0, 3'd3, 8'hFF, 64'h0,                   OOR_RESP};
        vecs[7] = '{1'b1, 32'h7FFF_FFF8, 8'd0, 3'd3, 8'hFF, 64'h0BAD_0BAD_0BAD_0BAD, OOR_RESP};
        vecs[8] = '{1'b1, 32'h8000_2000, 8'd0, 3'd3, 8'hFF, 64'h7777_0000_7777_0000, OOR_RESP};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);
        check("aw_ready_after_rst", 64'(bus.aw_ready), 64'd1);
        check("ar_ready_after_rst", 64'(bus.ar_ready), 64'd1);

        // Words 0..255 start at zero so partial-strobe vectors have a known background.
        do_write(BASE, 8'd255, 3'd3, 8'hFF, 64'd0, 4'd0, 2'b00);

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].do_wr)
                do_write(vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].strb, vecs[i].seed,
                         4'(i), vecs[i].exp_resp);
            do_read(vecs[i].addr, vecs[i].len, vecs[i].size, 4'(i + 6), vecs[i].exp_resp, 1'b0);
        end

        // Single-byte write into lane 2 over a zeroed word.
        do_write(32'h8000_0008, 8'd0, 3'd3, 8'hFF, 64'd0, 4'd3, 2'b00);
        do_write(32'h8000_0008, 8'd0, 3'd0, 8'h04, 64'h0000_0000_00AB_0000, 4'd4, 2'b00);
        do_read(32'h8000_0008, 8'd0, 3'd3, 4'd5, 2'b00, 1'b0);

        // Back-pressure: r_ready alternates 1,0,1,0.
        do_read(32'h8000_0100, 8'd3, 3'd3, 4'd9, 2'b00, 1'b1);

        // Reset after the first of four beats; that beat stays in memory.
        @(negedge clk);
        bus.aw_valid = 1'b1; bus.aw_addr = 32'h8000_0500; bus.aw_len = 8'd3;
        bus.aw_size = 3'd3; bus.aw_burst = 2'b01; bus.aw_id = 4'd2;
        check("mid_aw_ready", 64'(bus.aw_ready), 64'd1);
        @(negedge clk);
        bus.aw_valid = 1'b0;
        bus.w_valid = 1'b1; bus.w_data = 64'h5555_5555_5555_5555; bus.w_strb = 8'hFF; bus.w_last = 1'b0;
        check("mid_w_ready", 64'(bus.w_ready), 64'd1);
        m_write(m_idx(32'h8000_0500), 64'h5555_5555_5555_5555, 8'hFF);
        @(negedge clk);
        bus.w_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);
        check("aw_ready_post_rst", 64'(bus.aw_ready), 64'd1);
        check("w_ready_post_rst", 64'(bus.w_ready), 64'd0);
        do_read(32'h8000_0500, 8'd3, 3'd3, 4'd1, 2'b00, 1'b0);
        do_write(32'h8000_0600, 8'd1, 3'd3, 8'hFF, 64'h0123_4567_89AB_CDEF, 4'd7, 2'b00);
        do_read(32'h8000_0600, 8'd1, 3'd3, 4'd8, 2'b00, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
